// File: rtl/stack_program_loader.sv
// Program loader for the stack CPU: streams instruction words into program memory,
// holds the CPU in reset while loading and serves memory[pc], HALT-padded past the program.
module stack_program_loader #(
  parameter int INSTR_WIDTH    = 16,
  parameter int PC_WIDTH       = 8,
  parameter int PGRM_MEM_DEPTH = 256,
  parameter int HOLD_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   cpu_reset,
  input  logic                   cpu_halt,
  output logic [PC_WIDTH:0]      prog_len,
  output logic                   load_overflow,
  output logic                   running
);

  localparam int ADDR_W = (PGRM_MEM_DEPTH > 1) ? $clog2(PGRM_MEM_DEPTH) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = {5'b11111, {(INSTR_WIDTH-5){1'b0}}};
  localparam logic [PC_WIDTH:0]      LAST_LEN  = (PC_WIDTH+1)'(PGRM_MEM_DEPTH - 1);
  localparam logic [HOLD_W-1:0]      HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [PC_WIDTH:0]        prog_len_r;
  logic                     load_overflow_r;
  logic                     cpu_reset_r;
  logic                     running_r;
  logic [HOLD_W-1:0]        hold_cnt_r;
  logic [INSTR_WIDTH-1:0]   mem_r [PGRM_MEM_DEPTH];

  logic                     load_ready_s;
  logic                     accept_s;
  logic                     clear_s;
  logic                     overflow_s;
  logic [INSTR_WIDTH-1:0]   instruction_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; load_start outranks cpu_halt in RUN
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) state_next_s = ST_LOAD;
        else            state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (accept_s && load_last)                 state_next_s = ST_HOLD;
        else if (accept_s && prog_len_r == LAST_LEN) state_next_s = ST_IDLE;
        else                                       state_next_s = ST_LOAD;
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_ONE) state_next_s = ST_RUN;
        else                        state_next_s = ST_HOLD;
      end
      ST_RUN: begin
        if (load_start)    state_next_s = ST_LOAD;
        else if (cpu_halt) state_next_s = ST_HALTED;
        else               state_next_s = ST_RUN;
      end
      ST_HALTED: begin
        if (load_start) state_next_s = ST_LOAD;
        else            state_next_s = ST_HALTED;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode and instruction mux; memory is only exposed once the CPU is released
  always_comb begin
    load_ready_s  = (state_r == ST_LOAD);
    accept_s      = load_valid && load_ready_s;
    clear_s       = (state_next_s == ST_LOAD) && (state_r != ST_LOAD);
    overflow_s    = accept_s && !load_last && (prog_len_r == LAST_LEN);
    instruction_s = HALT_WORD;
    if (((state_r == ST_RUN) || (state_r == ST_HALTED)) && ({1'b0, pc} < prog_len_r)) begin
      instruction_s = mem_r[pc[ADDR_W-1:0]];
    end else begin
      instruction_s = HALT_WORD;
    end
  end

  // Length, overflow flag, hold counter and registered CPU controls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_len_r      <= '0;
      load_overflow_r <= 1'b0;
      hold_cnt_r      <= '0;
      cpu_reset_r     <= 1'b1;
      running_r       <= 1'b0;
    end else begin
      cpu_reset_r <= !((state_next_s == ST_RUN) || (state_next_s == ST_HALTED));
      running_r   <= (state_next_s == ST_RUN);
      if (clear_s)       prog_len_r <= '0;
      else if (accept_s) prog_len_r <= prog_len_r + (PC_WIDTH+1)'(1);
      if ((state_r == ST_IDLE) && load_start) load_overflow_r <= 1'b0;
      else if (overflow_s)                    load_overflow_r <= 1'b1;
      if (accept_s && load_last)    hold_cnt_r <= HOLD_INIT;
      else if (state_r == ST_HOLD)  hold_cnt_r <= hold_cnt_r - HOLD_ONE;
    end
  end

  // Program memory write port (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[prog_len_r[ADDR_W-1:0]] <= load_data;
    end
  end

  assign load_ready    = load_ready_s;
  assign instruction   = instruction_s;
  assign cpu_reset     = cpu_reset_r;
  assign prog_len      = prog_len_r;
  assign load_overflow = load_overflow_r;
  assign running       = running_r;

endmodule

// File: doc/stack_program_loader.md
Name: stack_program_loader

Overview:
- Upstream instruction source for the stack CPU; replaces the bench-only program-memory preload with synthesizable logic.
- Accepts a valid/ready stream of instruction words, writes them into program memory and holds the CPU in reset while loading.
- Releases the CPU after a fixed hold and serves instruction = memory[pc] combinationally, padding with HALT beyond the loaded program.

Parameters:
- INSTR_WIDTH, 16: instruction word width; format is {opcode[4:0], 1'b0, immediate[9:0]}.
- PC_WIDTH, 8: width of the CPU program counter.
- PGRM_MEM_DEPTH, 256: program memory words; must be <= 2**PC_WIDTH.
- HOLD_CYCLES, 2: cycles cpu_reset stays high after the last word is accepted (min 1).

Ports:
- clk  in  1: system clock; all state updates on posedge.
- reset  in  1: asynchronous, active-high reset.
- load_start  in  1: single-cycle pulse that begins a new program load.
- load_valid  in  1: load_data is valid this cycle.
- load_ready  out  1: loader can accept a word this cycle.
- load_data  in  INSTR_WIDTH: instruction word to store.
- load_last  in  1: qualifies load_data as the final program word.
- pc  in  PC_WIDTH: CPU program counter.
- instruction  out  INSTR_WIDTH: instruction presented to the CPU.
- cpu_reset  out  1: reset to the CPU; active-high, registered.
- cpu_halt  in  1: CPU halt OR error indication.
- prog_len  out  PC_WIDTH+1: number of words loaded.
- load_overflow  out  1: sticky flag; program exceeded memory depth.
- running  out  1: high in RUN state.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, HALTED.
- Reset values (async, immediate):
  - state = IDLE; cpu_reset = 1; load_ready = 0; prog_len = 0; load_overflow = 0; running = 0; write pointer = 0.
  - Memory contents are not reset.
- HALT_WORD = {5'b11111, (INSTR_WIDTH-5)'b0}; 16'hF800 at the default width.
- IDLE: cpu_reset = 1; load_ready = 0.
  - load_start -> LOAD; clears write pointer, prog_len and load_overflow.
- LOAD: load_ready = 1 (combinational from state); cpu_reset = 1.
  - A word is accepted on a posedge with load_valid && load_ready.
  - On accept: memory[wr_ptr] <= load_data; wr_ptr and prog_len increment.
  - Accepted word with load_last = 1 -> HOLD; hold counter loads HOLD_CYCLES.
  - Accepted word at address PGRM_MEM_DEPTH-1 with load_last = 0:
    - The word is stored and prog_len = PGRM_MEM_DEPTH.
    - load_overflow <= 1; state -> IDLE; the CPU is never released.
  - load_valid = 0: no change; no timeout.
- HOLD: cpu_reset = 1; counter decrements each cycle.
  - On the edge where the counter reaches 1 -> RUN, and cpu_reset registers 0 on that same edge.
  - cpu_reset is therefore high for exactly HOLD_CYCLES cycles after the edge that accepted the last word.
- RUN: cpu_reset = 0; running = 1.
  - cpu_halt sampled high -> HALTED.
- HALTED: cpu_reset = 0, so the CPU keeps its halt/error outputs visible. Waits for load_start.
- load_start handling:
  - In RUN or HALTED: -> LOAD; cpu_reset registers 1 on that edge; prog_len and the write pointer clear.
  - Ignored in LOAD and HOLD.
  - If load_start and cpu_halt are both high in RUN, load_start wins.
- instruction output (combinational):
  - RUN or HALTED with pc < prog_len: memory[pc].
  - All other cases: HALT_WORD, including pc >= prog_len and the IDLE, LOAD and HOLD states.
  - The CPU therefore halts cleanly when it runs off the end of the program.
- Write/read collision cannot occur: writes happen only in LOAD, and reads return memory data only in RUN/HALTED.
- Async reset mid-LOAD: discards progress; prog_len = 0; the CPU is held in reset.

Test Plan:
- Reset then load_start, then 3 words {0000_0_00000000101, 0000_0_00000000011, 00001_0_0000000000} with load_last on the 3rd -> prog_len = 3; cpu_reset falls exactly 2 cycles after the 3rd accept; instruction for pc = 0/1/2 matches the words; pc = 3 -> 16'hF800.
- Backpressure/gaps: toggle load_valid 1-0-1 across 4 words -> only cycles with valid && ready write; prog_len = 4; load_ready = 0 outside LOAD.
- Overflow: with PGRM_MEM_DEPTH = 4, send 4 words with load_last never set -> load_overflow = 1, state IDLE, cpu_reset stays 1, instruction = F800; a 5th load_valid is not accepted.
- Halt path: in RUN assert cpu_halt for 1 cycle -> HALTED, running = 0, cpu_reset stays 0; then load_start -> cpu_reset = 1 on the next edge, load_ready = 1, prog_len = 0.
- Async reset asserted mid-LOAD after 2 words -> all outputs take reset values immediately without a clock edge; a subsequent load of 1 word with load_last gives prog_len = 1.
- load_start pulsed during HOLD -> ignored; RUN is entered on schedule with prog_len unchanged.
